// File: rtl/instruction_fetcher.sv
// Instruction fetch unit: fetches words from memory, or from the optional direct-mapped icache
// when ICACHE_EN is defined, decodes the immediate and hands one instruction at a time to decode.
//
// state | meaning
// IDLE  | ready: hand off a cache hit or issue a memory request for fpc
// WAIT  | memory request for fpc outstanding
// HOLD  | fetched word latched, waiting for if_stall to fall
// DROP  | redirected while a request is outstanding; the response is discarded
module instruction_fetcher #(
    parameter int ICACHE_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_stall,
    input  logic        pc_bc_flag,
    input  logic [31:0] pc_bc,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_valid,
    input  logic [31:0] mc_data,
    output logic [31:0] ins,
    output logic        ins_flag,
    output logic [31:0] ins_imm,
    output logic [31:0] pc
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t      state, state_nx;
    logic [31:0] fpc, fpc_nx;
    logic [31:0] word_q, word_nx;
    logic        mc_req_nx;
    logic [31:0] mc_addr_nx;
    logic        hand_en;
    logic [31:0] hand_word, hand_imm;
    logic        fill;
    logic        cache_hit;
    logic [31:0] cache_word;

    function automatic logic [31:0] imm_of(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (w[6:0])
            7'b0010011: r = (w[14:12] == 3'b001 || w[14:12] == 3'b101)
                          ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
            7'b0000011, 7'b1100111: r = {{20{w[31]}}, w[31:20]};
            7'b0100011: r = {{20{w[31]}}, w[31:25], w[11:7]};
            7'b1100011: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'b0110111, 7'b0010111: r = {w[31:12], 12'b0};
            7'b1101111: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nx   = state;
        fpc_nx     = fpc;
        word_nx    = word_q;
        mc_req_nx  = mc_req;
        mc_addr_nx = mc_addr;
        hand_en    = 1'b0;
        hand_word  = word_q;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (pc_bc_flag) begin
                    fpc_nx = pc_bc;
                end else if (!if_stall) begin
                    if (cache_hit) begin
                        hand_en   = 1'b1;
                        hand_word = cache_word;
                    end else begin
                        mc_req_nx  = 1'b1;
                        mc_addr_nx = fpc;
                        state_nx   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mc_valid) begin
                    mc_req_nx = 1'b0;
                    fill      = 1'b1;
                    if (pc_bc_flag) begin
                        fpc_nx   = pc_bc;
                        state_nx = IDLE;
                    end else if (!if_stall) begin
                        hand_en   = 1'b1;
                        hand_word = mc_data;
                        state_nx  = IDLE;
                    end else begin
                        word_nx  = mc_data;
                        state_nx = HOLD;
                    end
                end else if (pc_bc_flag) begin
                    fpc_nx   = pc_bc;
                    state_nx = DROP;
                end
            end
            HOLD: begin
                if (pc_bc_flag) begin
                    fpc_nx   = pc_bc;
                    state_nx = IDLE;
                end else if (!if_stall) begin
                    hand_en  = 1'b1;
                    state_nx = IDLE;
                end
            end
            DROP: begin
                if (pc_bc_flag) fpc_nx = pc_bc;
                if (mc_valid) begin
                    mc_req_nx = 1'b0;
                    fill      = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        hand_imm = imm_of(hand_word);
        // Only JAL is resolved here; every other control transfer comes back as a redirect.
        if (hand_en) fpc_nx = fpc + ((hand_word[6:0] == OP_JAL) ? hand_imm : 32'd4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fpc      <= '0;
            word_q   <= '0;
            mc_req   <= 1'b0;
            mc_addr  <= '0;
            ins_flag <= 1'b0;
            ins      <= '0;
            ins_imm  <= '0;
            pc       <= '0;
        end else if (rdy) begin
            state    <= state_nx;
            fpc      <= fpc_nx;
            word_q   <= word_nx;
            mc_req   <= mc_req_nx;
            mc_addr  <= mc_addr_nx;
            ins_flag <= hand_en;
            if (hand_en) begin
                ins     <= hand_word;
                ins_imm <= hand_imm;
                pc      <= fpc;
            end
        end
    end

`ifdef ICACHE_EN
    localparam int DEPTH = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    logic [31:0]             cache_data [DEPTH];
    logic [TAG_W-1:0]        cache_tag  [DEPTH];
    logic [DEPTH-1:0]        cache_vld;
    logic [ICACHE_IDX_W-1:0] rd_idx, wr_idx;

    // Fills are indexed by the request address, since fpc may already have been redirected.
    assign rd_idx     = fpc[ICACHE_IDX_W+1:2];
    assign wr_idx     = mc_addr[ICACHE_IDX_W+1:2];
    assign cache_hit  = cache_vld[rd_idx] && (cache_tag[rd_idx] == fpc[31:ICACHE_IDX_W+2]);
    assign cache_word = cache_data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) cache_vld <= '0;
        else if (rdy && fill) cache_vld[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            cache_data[wr_idx] <= mc_data;
            cache_tag[wr_idx]  <= mc_addr[31:ICACHE_IDX_W+2];
        end
    end
`else
    logic                    unused_fill;
    logic [ICACHE_IDX_W-1:0] unused_idx;
    assign unused_fill = fill;
    assign unused_idx  = fpc[ICACHE_IDX_W+1:2];
    assign cache_hit   = 1'b0;
    assign cache_word  = '0;
`endif
endmodule
